// File: rtl/ni_packetizer.sv
// ni_packetizer: drains the NI write buffer into 32-bit NoC packets with XY direction
// and a 2-entry skid buffer so the router handshake sustains one packet per cycle.
module ni_packetizer #(
  parameter int          MSB_SLOT = 5,
  parameter logic [7:0]  LOCAL_X  = 8'd0,
  parameter logic [7:0]  LOCAL_Y  = 8'd0,
  localparam int         DSIZE    = 1 << MSB_SLOT,
  localparam int         RSIZE    = 1 << (MSB_SLOT - 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RSIZE-1:0] fifo_rdata,
  input  logic [RSIZE-1:0] fifo_raddr,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic [DSIZE-1:0] noc_packet,
  output logic [2:0]       noc_dir,
  output logic             noc_valid,
  input  logic             noc_ready,
  output logic [15:0]      pkt_count
);
  localparam logic [2:0] DIR_LOCAL = 3'd0, DIR_EAST = 3'd1, DIR_WEST = 3'd2,
                         DIR_NORTH = 3'd3, DIR_SOUTH = 3'd4;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  occ_e             occ_q, occ_d;
  logic [DSIZE-1:0] main_pkt_q, main_pkt_d, skid_pkt_q, skid_pkt_d;
  logic [2:0]       main_dir_q, main_dir_d, skid_dir_q, skid_dir_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       head_dir;
  logic [DSIZE-1:0] head_pkt;
  logic             pop, accept;
  // X is resolved before Y so packets follow dimension-ordered routing
  always_comb begin
    head_dir = fifo_raddr[15:8] > LOCAL_X ? DIR_EAST  :
               fifo_raddr[15:8] < LOCAL_X ? DIR_WEST  :
               fifo_raddr[7:0]  > LOCAL_Y ? DIR_NORTH :
               fifo_raddr[7:0]  < LOCAL_Y ? DIR_SOUTH : DIR_LOCAL;
    head_pkt = {fifo_raddr, fifo_rdata};
  end
  assign accept    = (occ_q != EMPTY) && noc_ready;
  assign pop       = !reset && !fifo_rempty && (occ_q != TWO);
  assign fifo_rinc = pop;
  always_comb begin
    occ_d      = occ_q;
    main_pkt_d = main_pkt_q;
    main_dir_d = main_dir_q;
    skid_pkt_d = skid_pkt_q;
    skid_dir_d = skid_dir_q;
    cnt_d      = accept ? cnt_q + 16'd1 : cnt_q;
    case (occ_q)
      EMPTY: if (pop) begin
        main_pkt_d = head_pkt;
        main_dir_d = head_dir;
        occ_d      = ONE;
      end
      ONE: if (pop && accept) begin
        main_pkt_d = head_pkt;
        main_dir_d = head_dir;
      end else if (pop) begin
        skid_pkt_d = head_pkt;
        skid_dir_d = head_dir;
        occ_d      = TWO;
      end else if (accept) begin
        occ_d = EMPTY;
      end
      TWO: if (accept) begin
        main_pkt_d = skid_pkt_q;
        main_dir_d = skid_dir_q;
        occ_d      = ONE;
      end
      default: occ_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q      <= EMPTY;
      main_pkt_q <= '0;
      main_dir_q <= DIR_LOCAL;
      skid_pkt_q <= '0;
      skid_dir_q <= DIR_LOCAL;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      main_pkt_q <= main_pkt_d;
      main_dir_q <= main_dir_d;
      skid_pkt_q <= skid_pkt_d;
      skid_dir_q <= skid_dir_d;
      cnt_q      <= cnt_d;
    end
  end
  assign noc_packet = main_pkt_q;
  assign noc_dir    = main_dir_q;
  assign noc_valid  = occ_q != EMPTY;
  assign pkt_count  = cnt_q;
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed bench with a FIFO model and an expected-packet scoreboard.
module tb_ni_packetizer;
  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] fifo_rdata, fifo_raddr;
  logic        fifo_rempty, fifo_rinc, noc_valid, noc_ready;
  logic [31:0] noc_packet;
  logic [2:0]  noc_dir;
  logic [15:0] pkt_count;
  typedef struct { logic [31:0] pkt; logic [2:0] dir; } exp_t;
  logic [31:0] fq[$];
  exp_t        exp_q[$];
  int vectors = 0, miscompares = 0, pops = 0;
  logic last_rinc, last_valid;
  ni_packetizer #(.MSB_SLOT(5), .LOCAL_X(8'd2), .LOCAL_Y(8'd2)) dut (
    .clk(clk), .reset(reset), .fifo_rdata(fifo_rdata), .fifo_raddr(fifo_raddr),
    .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc), .noc_packet(noc_packet),
    .noc_dir(noc_dir), .noc_valid(noc_valid), .noc_ready(noc_ready), .pkt_count(pkt_count));
  always #5 clk = ~clk;
  function automatic logic [2:0] ref_dir(input logic [15:0] a);
    if (a[15:8] > 8'd2) return 3'd1;
    if (a[15:8] < 8'd2) return 3'd2;
    if (a[7:0] > 8'd2) return 3'd3;
    if (a[7:0] < 8'd2) return 3'd4;
    return 3'd0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic drive();
    fifo_rempty = fq.size() == 0;
    {fifo_raddr, fifo_rdata} = fq.size() == 0 ? 32'h0 : fq[0];
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] d);
    fq.push_back({a, d});
    exp_q.push_back('{pkt: {a, d}, dir: ref_dir(a)});
    drive();
  endtask
  task automatic edge_pop();
    logic r;
    r = fifo_rinc;
    @(posedge clk);
    #1;
    if (r) begin
      pops++;
      void'(fq.pop_front());
    end
    drive();
  endtask
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_rinc  = fifo_rinc;
    last_valid = noc_valid;
    if (noc_valid && noc_ready) begin
      if (exp_q.size() == 0) chk("spurious_accept", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("pkt", noc_packet, e.pkt);
        chk("dir", {29'd0, noc_dir}, {29'd0, e.dir});
      end
    end
    #4;
    edge_pop();
  endtask
  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) step();
    chk("drain_timeout", exp_q.size(), 0);
  endtask
  initial begin
    int n_rinc, n_valid, p0;
    noc_ready = 1'b0;
    drive();
    #1;
    chk("rst_valid", {31'd0, noc_valid}, 0);
    chk("rst_pkt", noc_packet, 0);
    chk("rst_dir", {29'd0, noc_dir}, 0);
    chk("rst_cnt", {16'd0, pkt_count}, 0);
    chk("rst_rinc", {31'd0, fifo_rinc}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // single packet
    noc_ready = 1'b1;
    push(16'h0502, 16'h00AB);
    step();
    chk("single_rinc", {31'd0, last_rinc}, 1);
    chk("single_valid", {31'd0, noc_valid}, 1);
    chk("single_pkt", noc_packet, 32'h050200AB);
    chk("single_dir", {29'd0, noc_dir}, 1);
    step();
    chk("single_cnt", {16'd0, pkt_count}, 1);
    // direction sweep
    push(16'h0102, 16'h0001);
    push(16'h0203, 16'h0002);
    push(16'h0201, 16'h0003);
    push(16'h0202, 16'h0004);
    push(16'h0300, 16'h0005);
    drain(20);
    chk("sweep_cnt", {16'd0, pkt_count}, 6);
    // backpressure
    noc_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) push(16'h0400 + 16'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      step();
      if (i > 0) chk("bp_stable", noc_packet, exp_q[0].pkt);
    end
    chk("bp_pops", pops - p0, 2);
    chk("bp_rinc", {31'd0, fifo_rinc}, 0);
    noc_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_valid += int'(last_valid);
    end
    chk("bp_no_bubble", n_valid, 5);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_cnt", {16'd0, pkt_count}, 11);
    // streaming
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 16'h2000 + 16'(i));
    n_rinc = 0;
    n_valid = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i < 8) n_rinc += int'(last_rinc);
      if (i > 0) n_valid += int'(last_valid);
    end
    chk("stream_rinc", n_rinc, 8);
    chk("stream_valid", n_valid, 8);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_cnt", {16'd0, pkt_count}, 19);
    // counter wrap
    for (int i = 0; i < 65516; i++) push(16'(i % 5) << 8 | 16'(i % 3), 16'(i));
    drain(66000);
    chk("wrap_max", {16'd0, pkt_count}, 32'h0000FFFF);
    push(16'h0202, 16'hBEEF);
    drain(10);
    chk("wrap_zero", {16'd0, pkt_count}, 0);
    for (int i = 0; i < 6; i++) begin
      noc_ready = i[0];
      step();
    end
    chk("idle_ready_cnt", {16'd0, pkt_count}, 0);
    // reset mid-stream
    noc_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 4; i++) push(16'h0102, 16'h3000 + 16'(i));
    repeat (3) step();
    chk("mid_pops", pops - p0, 2);
    chk("mid_valid", {31'd0, noc_valid}, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, noc_valid}, 0);
    chk("mid_rst_cnt", {16'd0, pkt_count}, 0);
    chk("mid_rst_rinc", {31'd0, fifo_rinc}, 0);
    chk("mid_rst_pkt", noc_packet, 0);
    #1 reset = 1'b0;
    #1;
    edge_pop();
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    noc_ready = 1'b1;
    drain(20);
    chk("mid_after_cnt", {16'd0, pkt_count}, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ni_packetizer.md
Name: ni_packetizer

Overview:
- Read-side stage of the NI write path: drains the NI write buffer (the swnet async FIFO read port) and forms 32-bit NoC packets.
- Computes an XY output-direction for each packet.
- Presents each packet to the local router injection port with a valid/ready handshake.
- Sustains one packet per cycle under no backpressure, using a 2-entry skid buffer.

Parameters:
- MSB_SLOT, 5, log2 of packet width; DSIZE = 1<<MSB_SLOT (32), RSIZE = 1<<(MSB_SLOT-1) (16).
- LOCAL_X, 0, X coordinate of this router (8 bits).
- LOCAL_Y, 0, Y coordinate of this router (8 bits).

Ports:
- clk  input  1  system clock (FIFO read-side clock)
- reset  input  1  asynchronous active-high reset
- fifo_rdata  input  RSIZE  neuron-address half (first-word-fall-through; valid while fifo_rempty=0)
- fifo_raddr  input  RSIZE  destination router address: [15:8]=X, [7:0]=Y
- fifo_rempty  input  1  write buffer empty
- fifo_rinc  output  1  pop strobe; one entry consumed per cycle high
- noc_packet  output  DSIZE  {fifo_raddr, fifo_rdata}: router address in MSBs, neuron address in LSBs
- noc_dir  output  3  0=LOCAL, 1=EAST, 2=WEST, 3=NORTH, 4=SOUTH
- noc_valid  output  1  packet/dir valid
- noc_ready  input  1  router accepts when valid&ready
- pkt_count  output  16  packets accepted by the router, wraps at 65535->0

Behaviour:
- Reset (async, immediate): noc_valid=0, noc_packet=0, noc_dir=0, pkt_count=0, fifo_rinc=0, both skid entries empty. Any in-flight packet is discarded; the FIFO entry already popped is lost (documented).
- Direction, combinational on the FIFO head:
  - dx = raddr[15:8] vs LOCAL_X (unsigned); dy = raddr[7:0] vs LOCAL_Y.
  - X resolved first: dest X > LOCAL_X -> EAST; < -> WEST.
  - X equal: dest Y > LOCAL_Y -> NORTH; < -> SOUTH; equal -> LOCAL.
- Storage: output register (main) plus skid register; occupancy 0/1/2.
- Pop rule: fifo_rinc = !fifo_rempty && (occupancy < 2) && !(occupancy==1 && skid path would overflow). Equivalently, pop only when the popped word has a guaranteed slot at the next edge.
- Popped word placement:
  - Main empty, or main draining this cycle with skid empty -> main.
  - Otherwise -> skid.
- Output: noc_packet/noc_dir/noc_valid driven directly from the main register, with no combinational path from fifo_* to noc_*. Latency is 1 cycle from head presented with fifo_rinc=1 to noc_valid=1.
- Handshake:
  - Once noc_valid=1, noc_packet and noc_dir hold stable until the cycle noc_valid&noc_ready.
  - noc_valid never drops without acceptance.
  - On acceptance, main reloads from skid if skid is occupied, else from the FIFO if popping this cycle, else noc_valid=0.
- FSM on occupancy:
  - EMPTY: pop -> ONE.
  - ONE: pop&!accept -> TWO; accept&!pop -> EMPTY; accept&pop or neither -> ONE.
  - TWO: no pop; accept -> ONE.
- Simultaneous accept and pop in ONE: new word goes straight to main; back-to-back valid with no bubble.
- noc_ready held low indefinitely: at most 2 entries absorbed, then fifo_rinc=0; FIFO fills and backpressure reaches core_wfull.
- noc_ready high while noc_valid=0: no effect, pkt_count unchanged.
- pkt_count increments exactly on noc_valid&noc_ready and wraps 0xFFFF->0x0000.
- fifo_rempty high: fifo_rinc=0; fifo_rdata and fifo_raddr are ignored.

Test Plan:
- Reset mid-stream: 2 entries buffered, noc_valid=1, assert reset for a partial cycle -> noc_valid=0, pkt_count=0 immediately; no pop while reset is high.
- Single packet, LOCAL_X=2, LOCAL_Y=2, FIFO head raddr=0x0502, rdata=0x00AB, noc_ready=1 -> one cycle after pop: noc_packet=0x050200AB, noc_dir=EAST, pkt_count=1.
- Direction sweep with LOCAL=(2,2): raddr 0x0102->WEST, 0x0203->NORTH, 0x0201->SOUTH, 0x0202->LOCAL, 0x0300->EAST (X priority over Y).
- Backpressure: 5 entries queued, noc_ready=0 for 10 cycles -> exactly 2 pops, noc_packet stable; then noc_ready=1 -> remaining 5 delivered in order on 5 consecutive cycles, no bubble.
- Streaming: 8 entries queued, noc_ready=1 constant -> fifo_rinc high 8 consecutive cycles, 8 consecutive valid cycles, order preserved.
- Counter wrap: preload 65535 accepts (or force) -> next accept gives pkt_count=0; noc_ready toggled with noc_valid=0 -> no increment.
